// File: rtl/encoder_42_seq.sv
// encoder_42_seq: sequential 4-to-2 priority encoder with debounce and a
// valid/ack handshake. It is the inverse of the 2-to-4 decoder and sits between
// raw request/switch lines and decoder-driven logic.
//
// Ports:
//   Clk    - rising-edge clock
//   Rst_n  - asynchronous active-low reset
//   D_in   - request lines, bit 3 has the highest priority
//   Ack    - consumer acknowledge, sampled only while Valid=1
//   I_out  - encoded index of the highest active line (I1,I0)
//   Valid  - code available, held until acknowledged
//   Multi  - more than one line was set in the accepted code (qualified by Valid)
//
// Flow: IDLE -> DEBOUNCE (press must be stable DEB_CYCLES samples) -> VALID
// (wait for Ack) -> RELEASE (all-zero must be stable DEB_CYCLES samples) -> IDLE.
module encoder_42_seq #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] D_in,
  input  logic       Ack,
  output logic [1:0] I_out,
  output logic       Valid,
  output logic       Multi
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_VALID    = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       d_q;
  logic [3:0]       snap;

  function automatic logic [1:0] prio(input logic [3:0] v);
    if (v[3])      prio = 2'b11;
    else if (v[2]) prio = 2'b10;
    else if (v[1]) prio = 2'b01;
    else           prio = 2'b00;
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something.
  function automatic logic multi_hot(input logic [3:0] v);
    multi_hot = (v & (v - 4'd1)) != 4'd0;
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      d_q   <= '0;
      snap  <= '0;
      I_out <= 2'b00;
      Valid <= 1'b0;
      Multi <= 1'b0;
    end else begin
      // All decisions below look at the previous sample, never raw D_in.
      d_q <= D_in;
      case (state)
        S_IDLE: begin
          if (d_q != 4'd0) begin
            snap  <= d_q;
            cnt   <= '0;
            state <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (d_q == snap) begin
            if (cnt == CNT_MAX) begin
              // Accept: counter cleared rather than stepped past its ceiling.
              cnt   <= '0;
              I_out <= prio(snap);
              Multi <= multi_hot(snap);
              Valid <= 1'b1;
              state <= S_VALID;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (d_q == 4'd0) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            // Different nonzero pattern: restart debounce on the new code.
            snap <= d_q;
            cnt  <= '0;
          end
        end
        S_VALID: begin
          if (Ack) begin
            Valid <= 1'b0;
            cnt   <= '0;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (d_q == 4'd0) begin
            if (cnt == CNT_MAX) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_42_seq.sv
// Directed bench for encoder_42_seq with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_encoder_42_seq;

  localparam int DEB = 4;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] D_in;
  logic       Ack;
  logic [1:0] I_out;
  logic       Valid;
  logic       Multi;

  int checks   = 0;
  int failures = 0;

  encoder_42_seq #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .D_in  (D_in),
    .Ack   (Ack),
    .I_out (I_out),
    .Valid (Valid),
    .Multi (Multi)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge.
  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Press from IDLE (d_q already zero): Valid must rise exactly on edge DEB+2,
  // then stay for 'hold' cycles, then one Ack cycle, then a clean release.
  task automatic press(input logic [3:0] code, input int ei, input int em,
                       input int hold, input string tag);
    D_in = code;
    for (int i = 0; i < DEB + 1; i++) begin
      cyc();
      chk({tag, "_early"}, Valid, 0);
    end
    cyc();
    chk({tag, "_vld"}, Valid, 1);
    chk({tag, "_idx"}, I_out, ei);
    chk({tag, "_multi"}, Multi, em);
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk({tag, "_hold_vld"}, Valid, 1);
      chk({tag, "_hold_idx"}, I_out, ei);
    end
    Ack = 1'b1;
    cyc();
    Ack = 1'b0;
    chk({tag, "_ack_drop"}, Valid, 0);
    chk({tag, "_idx_kept"}, I_out, ei);
    D_in = 4'd0;
    repeat (DEB + 2) cyc();
  endtask

  initial begin
    Rst_n = 1'b0;
    D_in  = 4'd0;
    Ack   = 1'b0;
    #2;
    chk("rst_vld", Valid, 0);
    chk("rst_idx", I_out, 0);
    chk("rst_multi", Multi, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) cyc();

    // Asynchronous reset between edges.
    @(posedge Clk);
    #3 Rst_n = 1'b0;
    #1;
    chk("async_rst_vld", Valid, 0);
    chk("async_rst_idx", I_out, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_quiet", Valid, 0);
    end
    chk("idle_idx", I_out, 0);
    chk("idle_multi", Multi, 0);

    // Single line with a long hold before Ack.
    press(4'b0100, 2, 0, 10, "single");
    // Priority patterns.
    press(4'b1011, 3, 1, 0, "p1011");
    press(4'b0011, 1, 1, 0, "p0011");
    press(4'b0001, 0, 0, 0, "p0001");

    // Bounce: 2-cycle toggles never reach Valid.
    for (int s = 0; s < 6; s++) begin
      D_in = (s % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (2) begin
        cyc();
        chk("bounce_novld", Valid, 0);
      end
    end
    press(4'b0010, 1, 0, 0, "bounce_steady");

    // Release debounce: held press after Ack never re-triggers, short zero
    // runs do not return to IDLE.
    D_in = 4'b1000;
    repeat (DEB + 2) cyc();
    chk("rel_vld", Valid, 1);
    chk("rel_idx", I_out, 3);
    Ack = 1'b1;
    cyc();
    Ack = 1'b0;
    chk("rel_ack", Valid, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rel_held", Valid, 0);
    end
    D_in = 4'd0;
    repeat (2) begin
      cyc();
      chk("rel_glitch", Valid, 0);
    end
    D_in = 4'b1000;
    repeat (3) begin
      cyc();
      chk("rel_back", Valid, 0);
    end
    // Only three zero samples, then a new press: still in RELEASE.
    D_in = 4'd0;
    repeat (3) cyc();
    D_in = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rel_short_zero", Valid, 0);
    end
    chk("rel_idx_kept", I_out, 3);
    D_in = 4'd0;
    repeat (DEB + 2) cyc();
    press(4'b0001, 0, 0, 0, "after_rel");

    // Ack tied high through a press: Valid lasts exactly one cycle.
    Ack  = 1'b1;
    D_in = 4'b0100;
    for (int i = 0; i < DEB + 1; i++) begin
      cyc();
      chk("ackhi_early", Valid, 0);
    end
    cyc();
    chk("ackhi_vld", Valid, 1);
    chk("ackhi_idx", I_out, 2);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("ackhi_once", Valid, 0);
    end
    Ack  = 1'b0;
    D_in = 4'd0;
    repeat (DEB + 2) cyc();

    // Reset while VALID.
    D_in = 4'b1000;
    repeat (DEB + 2) cyc();
    chk("rstv_pre", Valid, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("rstv_vld", Valid, 0);
    chk("rstv_idx", I_out, 0);
    D_in = 4'd0;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rstv_quiet", Valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_42_seq.md
Name: encoder_42_seq

Overview:
- Sequential 4-to-2 priority encoder; the inverse of the team's 2-to-4 decoder.
- Samples four request lines D_in[3:0] (same bit order as decoder outputs D3..D0) and debounces them.
- Emits the 2-bit index I_out (I1,I0) of the highest active line, with a valid/ack handshake.
- Waits for all lines to release before accepting a new code; sits between raw request/switch inputs and downstream decoder-driven logic.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles required to accept a press or a release (legal range 2..2^CNT_W-1).
- CNT_W, 3, width of the debounce counter.

Ports:
- Clk  input  1  rising-edge system clock.
- Rst_n  input  1  asynchronous active-low reset.
- D_in  input  4  request lines; bit 3 has highest priority.
- Ack  input  1  consumer acknowledge; sampled only while Valid=1.
- I_out  output  2  encoded index; I_out[1]=I1, I_out[0]=I0.
- Valid  output  1  code available; held until acknowledged.
- Multi  output  1  more than one line was active in the accepted code; qualified by Valid.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low (Clk, Rst_n).
  - While Rst_n=0: state=IDLE, counter=0, sample register d_q=0, snapshot=0, I_out=2'b00, Valid=0, Multi=0.
  - Reset asserted mid-operation aborts immediately, regardless of state; no Valid pulse survives it.
- Input sampling: d_q <= D_in on every Clk edge. All decisions use d_q, never raw D_in. All outputs are registered.
- States:
  - IDLE: d_q!=0 -> snap<=d_q, cnt<=0, go DEBOUNCE. Otherwise stay.
  - DEBOUNCE, d_q==snap: cnt<=cnt+1. When cnt==DEB_CYCLES-1 -> VALID. On that same edge: I_out<=priority(snap), Multi<=(popcount(snap)>1), Valid<=1.
  - DEBOUNCE, d_q!=snap and d_q==0: go IDLE, cnt<=0.
  - DEBOUNCE, d_q!=snap and d_q!=0: snap<=d_q, cnt<=0, stay in DEBOUNCE (restart).
  - VALID: I_out, Multi and Valid are held constant. On an edge with Ack=1: Valid<=0, cnt<=0, go RELEASE. Changes on D_in are ignored in this state.
  - RELEASE: d_q==0 -> cnt<=cnt+1; at cnt==DEB_CYCLES-1 -> IDLE, cnt<=0. Any d_q!=0 -> cnt<=0, stay in RELEASE. I_out and Multi keep their last values; Valid=0.
- Priority function: bit3 -> 2'b11, bit2 -> 2'b10, bit1 -> 2'b01, bit0 -> 2'b00.
- Latency: D_in stable and nonzero before edge 1 -> Valid rises after edge DEB_CYCLES+2 (edge 6 at default).
- Handshake boundary cases:
  - Ack while Valid=0 is ignored.
  - Ack held high continuously: Valid stays high for exactly one cycle, then drops.
  - At most one Valid assertion per press; a held press never re-triggers.
  - A new code is accepted only after a debounced release.
- Counter: never exceeds DEB_CYCLES-1 and never wraps.

Test Plan:
- Reset: Rst_n=0 asserted asynchronously mid-clock -> I_out=00, Valid=0, Multi=0 immediately. Release, D_in=0 for 20 cycles -> outputs unchanged.
- Single line: D_in=4'b0100 held, Ack=0 -> Valid=1 after edge 6, I_out=10, Multi=0. Valid held for 10 cycles. Ack=1 for one cycle -> Valid=0 on next edge.
- Priority: D_in=4'b1011 stable -> I_out=11, Multi=1. Repeat with D_in=4'b0011 -> I_out=01, Multi=1. Repeat with D_in=4'b0001 -> I_out=00, Multi=0.
- Bounce: D_in toggles 0010/0000 every 2 cycles for 12 cycles, then 0010 steady -> no Valid during toggling. Valid=1, I_out=01 exactly DEB_CYCLES+2 edges after it goes steady.
- Release debounce: after Ack, D_in stays 1000 for 5 cycles, glitches to 0 for 2 cycles, back to 1000, then 0 -> no new Valid. IDLE re-entered only after 4 consecutive zero samples. A following D_in=0001 press yields I_out=00.
- Ack abuse: Ack tied high throughout a press -> Valid high exactly 1 cycle. Reset asserted while in VALID -> Valid=0 at once, and no code is produced after reset release while D_in=0.
